// File: rtl/msk_aes_invsr_col_buffer_if.sv
// Column handshake bundle for the masked InvShiftRows buffer: d-share input column in, shifted column out.
// Pure wiring; the buffer holds the slave side, the producer/consumer pair holds the master side.
interface msk_aes_invsr_col_buffer_if #(
   parameter int d = 2
);
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [8*d-1:0] in_b0;
   logic [8*d-1:0] in_b1;
   logic [8*d-1:0] in_b2;
   logic [8*d-1:0] in_b3;
   logic           out_valid;
   logic           out_ready;
   logic [8*d-1:0] out_b0;
   logic [8*d-1:0] out_b1;
   logic [8*d-1:0] out_b2;
   logic [8*d-1:0] out_b3;
   logic [1:0]     out_idx;
   logic           out_last;

   modport master (
      output flush, in_valid, in_b0, in_b1, in_b2, in_b3, out_ready,
      input  in_ready, out_valid, out_b0, out_b1, out_b2, out_b3, out_idx, out_last
   );

   modport slave (
      input  flush, in_valid, in_b0, in_b1, in_b2, in_b3, out_ready,
      output in_ready, out_valid, out_b0, out_b1, out_b2, out_b3, out_idx, out_last
   );
endinterface

// File: rtl/msk_aes_invsr_col_buffer.sv
// Masked 4-column state buffer replaying columns with InvShiftRows; first column valid 1 cycle after 4th accept, 8 cycles/state.
// Backpressure: in_ready low while draining, out_ready low freezes the output column; MSK_COLBUF_ZEROIZE_EN wipes idle data.
module msk_aes_invsr_col_buffer #(
   parameter int d = 2
) (
   input  logic clk,
   input  logic rst,
   msk_aes_invsr_col_buffer_if.slave bus
);
   localparam int W = 8*d;
   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   logic [0:0]   state_q, state_d;
   logic [1:0]   wc_q, wc_d;
   logic [1:0]   rc_q, rc_d;
   logic [W-1:0] s_q [4][4];
   logic [W-1:0] s_d [4][4];
   logic [W-1:0] in_b  [4];
   logic [W-1:0] mux_b [4];
   logic [W-1:0] out_mask;
   logic         in_rdy, out_vld, in_acc, out_acc;

   assign in_b[0] = bus.in_b0;
   assign in_b[1] = bus.in_b1;
   assign in_b[2] = bus.in_b2;
   assign in_b[3] = bus.in_b3;

   assign in_rdy  = (state_q == FILL);
   assign out_vld = (state_q == DRAIN);
   assign in_acc  = bus.in_valid & in_rdy & ~bus.flush;
   assign out_acc = out_vld & bus.out_ready & ~bus.flush;

   // Row r of output column rc comes from stored column (rc - r) mod 4.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         mux_b[r] = s_q[r][rc_q - 2'(r)];
      end
   end

`ifdef MSK_COLBUF_ZEROIZE_EN
   assign out_mask = {W{out_vld}};
`else
   assign out_mask = '1;
`endif

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.out_b0    = mux_b[0] & out_mask;
   assign bus.out_b1    = mux_b[1] & out_mask;
   assign bus.out_b2    = mux_b[2] & out_mask;
   assign bus.out_b3    = mux_b[3] & out_mask;
   assign bus.out_idx   = rc_q;
   assign bus.out_last  = out_vld & (rc_q == 2'd3);

   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      rc_d    = rc_q;
      s_d     = s_q;
      if (bus.flush) begin
         state_d = FILL;
         wc_d    = '0;
         rc_d    = '0;
`ifdef MSK_COLBUF_ZEROIZE_EN
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               s_d[r][c] = '0;
            end
         end
`endif
      end else if (in_acc) begin
         for (int r = 0; r < 4; r++) begin
            s_d[r][wc_q] = in_b[r];
         end
         wc_d = wc_q + 2'd1;
         if (wc_q == 2'd3) begin
            state_d = DRAIN;
         end
      end else if (out_acc) begin
         rc_d = rc_q + 2'd1;
         if (rc_q == 2'd3) begin
            state_d = FILL;
`ifdef MSK_COLBUF_ZEROIZE_EN
            // Final column consumed: every stored share has had its last use.
            for (int r = 0; r < 4; r++) begin
               for (int c = 0; c < 4; c++) begin
                  s_d[r][c] = '0;
               end
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         wc_q    <= '0;
         rc_q    <= '0;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               s_q[r][c] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         rc_q    <= rc_d;
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               s_q[r][c] <= s_d[r][c];
            end
         end
      end
   end
endmodule

// File: tb/tb_msk_aes_invsr_col_buffer.sv
// Bench for the masked InvShiftRows column buffer: directed table, scoreboard on every output column, corner sequences.
// Field layout for d=2: each 16-bit field is {share1, share0}; MSK_COLBUF_ZEROIZE_EN enables the extra zeroize checks.
module tb_msk_aes_invsr_col_buffer;
   localparam int D = 2;
   localparam int W = 8*D;

   typedef struct packed {
      logic [63:0] b;
      logic [1:0]  idx;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic [31:0] in_col;
      logic [31:0] exp_col;
      logic [1:0]  idx;
      logic        last;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   msk_aes_invsr_col_buffer_if #(.d(D)) bus ();
   msk_aes_invsr_col_buffer #(.d(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int out_n = 0;
   int last_out_cyc = 0;
   int m_wc = 0;
   exp_t q[$];
   logic [W-1:0] m_s [4][4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   function automatic logic [63:0] out_bus();
      return {bus.out_b3, bus.out_b2, bus.out_b1, bus.out_b0};
   endfunction

   function automatic logic [63:0] widen(input logic [31:0] x);
      return {8'h00, x[31:24], 8'h00, x[23:16], 8'h00, x[15:8], 8'h00, x[7:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_col(input logic [63:0] c);
      bus.in_b0 = c[15:0];
      bus.in_b1 = c[31:16];
      bus.in_b2 = c[47:32];
      bus.in_b3 = c[63:48];
   endtask

   // Scoreboard: golden InvShiftRows model fed by observed input accepts.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.out_valid && bus.out_ready && !bus.flush) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got column idx %0d, expected none", bus.out_idx);
            end else begin
               e = q.pop_front();
               check("sb_b", out_bus(), e.b);
               check("sb_idx", 64'(bus.out_idx), 64'(e.idx));
               check1("sb_last", bus.out_last, e.last);
            end
            out_n++;
            last_out_cyc = cyc;
         end
         if (bus.flush) begin
            m_wc = 0;
         end else if (bus.in_valid && bus.in_ready) begin
            m_s[0][m_wc] = bus.in_b0;
            m_s[1][m_wc] = bus.in_b1;
            m_s[2][m_wc] = bus.in_b2;
            m_s[3][m_wc] = bus.in_b3;
            if (m_wc == 3) begin
               for (int c = 0; c < 4; c++) begin
                  e.b    = {m_s[3][(c+1)%4], m_s[2][(c+2)%4], m_s[1][(c+3)%4], m_s[0][c]};
                  e.idx  = 2'(c);
                  e.last = (c == 3);
                  q.push_back(e);
               end
               m_wc = 0;
            end else begin
               m_wc++;
            end
         end
      end
   end

   task automatic stream(input int n, input string name);
      int t0, target, guard;
      t0 = 0;
      target = out_n + 4*n;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 4*n; k++) begin
         drive_col({$urandom, $urandom});
         guard = 0;
         while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
         end
         step();
         if (k == 0) t0 = cyc;
      end
      bus.in_valid = 1'b0;
      guard = 0;
      while (out_n < target && guard < 100) begin
         step();
         guard++;
      end
      repeat (3) step();
      check({name, "_cols"}, 64'(out_n), 64'(target));
      check({name, "_cycles"}, 64'(last_out_cyc + 1 - t0), 64'(8*n - 1));
   endtask

   task automatic fill_table(input vec_t v [4]);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_col(widen(v[i].in_col));
         step();
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vec [4];
      int guard;
      vec[0] = '{in_col: 32'h03020100, exp_col: 32'h070A0D00, idx: 2'd0, last: 1'b0};
      vec[1] = '{in_col: 32'h07060504, exp_col: 32'h0B0E0104, idx: 2'd1, last: 1'b0};
      vec[2] = '{in_col: 32'h0B0A0908, exp_col: 32'h0F020508, idx: 2'd2, last: 1'b0};
      vec[3] = '{in_col: 32'h0F0E0D0C, exp_col: 32'h0306090C, idx: 2'd3, last: 1'b1};

      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      drive_col('0);
      rst = 1'b1;
      repeat (2) step();
      check1("rst_in_ready", bus.in_ready, 1'b1);
      check1("rst_out_valid", bus.out_valid, 1'b0);
      check1("rst_out_last", bus.out_last, 1'b0);
      check("rst_out_idx", 64'(bus.out_idx), 64'd0);
      check("rst_out_b", out_bus(), 64'd0);
      rst = 1'b0;
      step();

      // Directed table: bytes 4c+r in, InvShiftRows columns out.
      bus.out_ready = 1'b1;
      fill_table(vec);
      for (int i = 0; i < 4; i++) begin
         check1("tbl_valid", bus.out_valid, 1'b1);
         check1("tbl_in_ready", bus.in_ready, 1'b0);
         check("tbl_b", out_bus(), widen(vec[i].exp_col));
         check("tbl_idx", 64'(bus.out_idx), 64'(vec[i].idx));
         check1("tbl_last", bus.out_last, vec[i].last);
         step();
      end
      check1("tbl_done_in_ready", bus.in_ready, 1'b1);
      check1("tbl_done_valid", bus.out_valid, 1'b0);
`ifdef MSK_COLBUF_ZEROIZE_EN
      check("tbl_zero_after_drain", out_bus(), 64'd0);
`endif

      stream(3, "b2b3");
      stream(100, "rand100");

      // Stall at rc=1 with in_valid held high.
      bus.out_ready = 1'b0;
      fill_table(vec);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      drive_col({$urandom, $urandom});
      for (int k = 0; k < 5; k++) begin
         check1("stall_valid", bus.out_valid, 1'b1);
         check1("stall_in_ready", bus.in_ready, 1'b0);
         check("stall_idx", 64'(bus.out_idx), 64'd1);
         check("stall_b", out_bus(), widen(vec[1].exp_col));
         step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         check("stall_rel_b", out_bus(), widen(vec[i].exp_col));
         check("stall_rel_idx", 64'(bus.out_idx), 64'(vec[i].idx));
         step();
      end
      check1("stall_done_in_ready", bus.in_ready, 1'b1);

      // Flush after two accepted columns; the colliding handshake is discarded.
      bus.in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         drive_col({$urandom, $urandom});
         step();
      end
      bus.flush = 1'b1;
      drive_col({$urandom, $urandom});
      step();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      check1("flush_in_ready", bus.in_ready, 1'b1);
      check1("flush_out_valid", bus.out_valid, 1'b0);
`ifdef MSK_COLBUF_ZEROIZE_EN
      check("flush_out_b_zero", out_bus(), 64'd0);
`endif
      bus.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive_col({$urandom, $urandom});
         step();
      end
      bus.in_valid = 1'b0;
      check1("flush_refill_valid", bus.out_valid, 1'b1);
      guard = 0;
      while ((q.size() != 0 || bus.out_valid) && guard < 50) begin
         step();
         guard++;
      end
      check("flush_sb_empty", 64'(q.size()), 64'd0);

      // Async reset mid-drain at rc=2.
      bus.out_ready = 1'b0;
      fill_table(vec);
      bus.out_ready = 1'b1;
      step();
      step();
      check("prerst_idx", 64'(bus.out_idx), 64'd2);
      bus.out_ready = 1'b0;
      #2;
      rst = 1'b1;
      q.delete();
      m_wc = 0;
      #1;
      check1("arst_out_valid", bus.out_valid, 1'b0);
      check1("arst_in_ready", bus.in_ready, 1'b1);
      check("arst_out_idx", 64'(bus.out_idx), 64'd0);
      check("arst_out_b", out_bus(), 64'd0);
      step();
      rst = 1'b0;
      step();

      stream(1, "post_rst");
`ifdef MSK_COLBUF_ZEROIZE_EN
      check("final_zero_b", out_bus(), 64'd0);
`endif
      check("final_sb_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
